scrub_fifo_stage: RTL and testbench
===================================

// Module: scrub_fifo_stage
// PURPOSE
//   Downstream buffering stage for the 8-bit data register path. Accepts bytes over valid/ready
//   and holds them in a small FIFO. Every storage entry is zeroized when its data is consumed,
//   on flush, and after reset, so no stale sensitive byte stays in storage or is driven out.
// PARAMETERS
//   DATA_W  8  data width in bits
//   DEPTH   4  number of FIFO entries; power of 2, >= 2; AW = $clog2(DEPTH) (localparam)
// PORTS
//   clk         in   1       clock, all logic on rising edge
//   rst         in   1       reset, synchronous, active-high
//   in_valid    in   1       upstream byte valid
//   in_ready    out  1       stage can accept a byte
//   in_data     in   DATA_W  upstream byte
//   out_valid   out  1       head entry valid
//   out_ready   in   1       downstream accepts head
//   out_data    out  DATA_W  head byte; all-zero whenever out_valid=0
//   flush       in   1       discard contents and scrub all storage
//   scrub_busy  out  1       scrub pass in progress
//   count       out  AW+1    current occupancy, 0..DEPTH
// BEHAVIOUR
//   - FSM states: SCRUB, RUN. While rst=1: state=SCRUB, scrub_idx=0, wr_ptr=rd_ptr=0, count=0.
//   - Output values while rst=1 and right after release: in_ready=0, out_valid=0,
//     out_data=0, scrub_busy=1, count=0.
//   - SCRUB: each cycle write mem[scrub_idx]<=0 and increment scrub_idx. The cycle that
//     writes scrub_idx==DEPTH-1 moves the FSM to RUN. A scrub pass lasts exactly DEPTH cycles.
//     flush during SCRUB is ignored. In SCRUB, in_ready=0 and out_valid=0.
//   - scrub_busy = (state==SCRUB).
//   - RUN outputs:
//     - in_ready  = !flush && count!=DEPTH
//     - out_valid = !flush && count!=0
//     - out_data  = out_valid ? mem[rd_ptr] : 0
//   - Push (in_valid&&in_ready): mem[wr_ptr]<=in_data; wr_ptr++ mod DEPTH; count++.
//   - Pop (out_valid&&out_ready): mem[rd_ptr]<=0 on the same edge; rd_ptr++ mod DEPTH; count--.
//   - Push and pop in the same cycle: both happen and count is unchanged. wr_ptr!=rd_ptr is
//     guaranteed (push is blocked at full, pop is blocked at empty), so there is no
//     write conflict.
//   - Full: a push is not accepted and in_data is not stored.
//   - Empty: out_data=0.
//   - Latency: a byte pushed at edge N is visible on out_data/out_valid after edge N.
//   - flush=1 in RUN: both handshakes are suppressed that cycle. On the edge: state=SCRUB,
//     scrub_idx=0, pointers=0, count=0. All held data is lost and then zeroized.
//   - rst mid-operation behaves like a flush: data is dropped, then a full scrub pass runs.
// CONFIGURATION
//   SCRUB_CNT_EN defined:
//     - adds output port scrub_cnt [7:0], a count of completed scrub passes.
//     - increments on each SCRUB->RUN transition and saturates at 255.
//     - rst sets it to 0; completion of the post-reset scrub sets it to 1.
//   SCRUB_CNT_EN undefined: no scrub_cnt port and no counter logic.
// TESTING (DATA_W=8, DEPTH=4)
//   1. Hold rst=1 for 2 cycles, then release.
//      -> scrub_busy=1 for exactly 4 cycles; in_ready=0 and out_data=0x00 throughout;
//      -> then in_ready=1, count=0.
//   2. Push 0xA1,0xB2,0xC3,0xD4, then offer 0xE5.
//      -> count=4, in_ready=0, 0xE5 not stored.
//      -> Pop 4 times: outputs 0xA1,0xB2,0xC3,0xD4 in order; then out_valid=0, out_data=0x00.
//   3. At count=2, push 0x11 and pop in the same cycle.
//      -> count stays 2; pop order is preserved, with 0x11 last.
//   4. Push 0x5A, then pop it.
//      -> the mem entry reads 0x00 by hierarchical peek on the next cycle; out_data=0x00.
//   5. At count=3, assert flush with in_valid=1 (in_data=0x77).
//      -> 0x77 not stored; count=0; scrub_busy=1 for 4 cycles; all entries 0x00; no out_valid.
//   6. Build with SCRUB_CNT_EN.
//      -> scrub_cnt=1 after the reset scrub and 2 after test 5's flush.
//      -> 300 flushes leave scrub_cnt=255.

Source files
------------

// File: rtl/scrub_fifo_stage.sv
// ============================================================================
// Module      : scrub_fifo_stage
// Description : Zeroizing valid/ready byte FIFO. Storage is scrubbed after
//               reset and flush, and each entry is cleared as it is popped.
//               Optional define SCRUB_CNT_EN adds the scrub_cnt pass counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scrub_fifo_stage #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic              scrub_busy,
`ifdef SCRUB_CNT_EN
  output logic [AW:0]       count,
  output logic [7:0]        scrub_cnt
`else
  output logic [AW:0]       count
`endif
);

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [AW:0]   c_full     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);
  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH-1);

  state_t            r_state;
  logic [AW-1:0]     r_scrub_idx;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_run;
  logic w_push;
  logic w_pop;

  // Outputs are forced idle while rst is high, before state has been reset.
  always_comb begin
    w_run      = !rst && (r_state == RUN);
    in_ready   = w_run && !flush && (r_count != c_full);
    out_valid  = w_run && !flush && (r_count != '0);
    out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    scrub_busy = rst || (r_state == SCRUB);
    count      = rst ? '0 : r_count;
  end

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCRUB;
      r_scrub_idx <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else if (r_state == SCRUB) begin
      r_scrub_idx <= r_scrub_idx + c_ptr_one;
      if (r_scrub_idx == c_last_idx) begin
        r_state <= RUN;
      end
    end else if (flush) begin
      r_state     <= SCRUB;
      r_scrub_idx <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  // Push and pop never target the same entry: push is blocked at full, pop at empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == SCRUB) begin
        r_mem[r_scrub_idx] <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= in_data;
        end
        if (w_pop) begin
          r_mem[r_rd_ptr] <= '0;
        end
      end
    end
  end

`ifdef SCRUB_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      scrub_cnt <= 8'd0;
    end else if ((r_state == SCRUB) && (r_scrub_idx == c_last_idx) && (scrub_cnt != 8'hFF)) begin
      scrub_cnt <= scrub_cnt + 8'd1;
    end
  end
`else
  // No pass counter in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_scrub_fifo_stage.sv
// Scoreboard bench for scrub_fifo_stage: directed scenarios followed by random traffic
// checked against a queue-based reference model.
`default_nettype none

module tb_scrub_fifo_stage;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              scrub_busy;
  logic [2:0]        count;
`ifdef SCRUB_CNT_EN
  logic [7:0]        scrub_cnt;
`endif

  scrub_fifo_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .scrub_busy (scrub_busy),
`ifdef SCRUB_CNT_EN
    .count      (count),
    .scrub_cnt  (scrub_cnt)
`else
    .count      (count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the number of scrub cycles still to run.
  logic [7:0] exp_q[$];
  int         m_cnt        = 0;
  int         m_scrub_left = DEPTH;
  int         m_passes     = 0;
  bit         m_busy, m_ir, m_ov;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_scrub_busy", scrub_busy, 1);
      check("rst_count", count, 0);
      exp_q.delete();
      m_cnt        = 0;
      m_scrub_left = DEPTH;
      m_passes     = 0;
    end else begin
      m_busy = (m_scrub_left > 0);
      m_ir   = !m_busy && !flush && (m_cnt < DEPTH);
      m_ov   = !m_busy && !flush && (m_cnt > 0);
      check("scrub_busy", scrub_busy, m_busy);
      check("in_ready", in_ready, m_ir);
      check("out_valid", out_valid, m_ov);
      check("count", count, m_cnt);
`ifdef SCRUB_CNT_EN
      check("scrub_cnt", scrub_cnt, m_passes);
`endif
      // Nothing live is held, so every entry must read back as zero.
      if (!m_busy && m_cnt == 0) begin
        for (int i = 0; i < DEPTH; i++) check("mem_zero", dut.r_mem[i], 0);
      end
      if (m_busy) begin
        m_scrub_left--;
        if (m_scrub_left == 0 && m_passes < 255) m_passes++;
      end else if (flush) begin
        exp_q.delete();
        m_cnt        = 0;
        m_scrub_left = DEPTH;
      end else begin
        if (in_valid && m_ir) begin
          exp_q.push_back(in_data);
          m_cnt++;
        end
        if (m_ov && out_ready) m_cnt--;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes an output handshake.
  always @(negedge clk) begin
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_underflow", 1, 0);
        end else begin
          check("pop_data", out_data, exp_q.pop_front());
        end
      end
    end else begin
      check("idle_data_zero", out_data, 0);
    end
  end

  task automatic drive(input bit iv, input logic [7:0] d, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0);
  endtask

  initial begin
    int r;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(6);

    // Fill, overflow attempt, drain.
    drive(1, 8'hA1, 0, 0);
    drive(1, 8'hB2, 0, 0);
    drive(1, 8'hC3, 0, 0);
    drive(1, 8'hD4, 0, 0);
    drive(1, 8'hE5, 0, 0);
    repeat (4) drive(0, 8'h00, 1, 0);
    idle(2);

    // Simultaneous push and pop at count=2.
    drive(1, 8'h01, 0, 0);
    drive(1, 8'h02, 0, 0);
    drive(1, 8'h11, 1, 0);
    repeat (3) drive(0, 8'h00, 1, 0);
    idle(1);

    // Single byte through, then the entry must be scrubbed.
    drive(1, 8'h5A, 0, 0);
    drive(0, 8'h00, 1, 0);
    idle(2);

    // Flush at count=3 with a concurrent push offer.
    drive(1, 8'h31, 0, 0);
    drive(1, 8'h32, 0, 0);
    drive(1, 8'h33, 0, 0);
    drive(1, 8'h77, 1, 1);
    repeat (6) drive(0, 8'h00, 1, 0);

    // Random traffic with occasional flush and mid-stream reset.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 199);
      rst = (r == 0);
      drive(($urandom % 2) == 0, 8'($urandom), (i < 400) ? (($urandom % 4) == 0) : (($urandom % 4) != 0),
            (r >= 1 && r <= 6));
    end
    rst = 1'b0;
    idle(6);
    repeat (6) drive(0, 8'h00, 1, 0);

`ifdef SCRUB_CNT_EN
    for (int i = 0; i < 300; i++) begin
      drive(0, 8'h00, 0, 1);
      idle(DEPTH);
    end
    idle(2);
    check("scrub_cnt_sat", scrub_cnt, 255);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
